stream_kernel_sequencer: RTL and testbench
==========================================

STREAM_KERNEL_SEQUENCER -- requirements
Module: stream_kernel_sequencer

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, active lines per frame.
REQ-003 Parameter LATENCY, default 2, clock cycles from window acceptance to the convolution result being registered at the kernel output.
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port pix_valid  input  1  one input pixel is presented this cycle.
REQ-007 Port sof  input  1  start of frame, qualified by pix_valid; marks pixel (0,0).
REQ-008 Port mode_req  input  2  requested kernel-select code.
REQ-009 Port mode_active  output  2  kernel-select code in force for the current frame.
REQ-010 Port shift_en  output  1  advance the line buffers and the 3x3 window.
REQ-011 Port col  output  $clog2(WIDTH)  column of the last accepted pixel.
REQ-012 Port row  output  $clog2(HEIGHT)  row of the last accepted pixel.
REQ-013 Port win_valid  output  1  the 3x3 window is fully populated this cycle.
REQ-014 Port out_valid  output  1  the kernel output carries a valid result.
REQ-015 Port frame_done  output  1  one-cycle pulse when the last result of a frame is out.
REQ-016 Port resync  output  1  one-cycle pulse when a frame is aborted by an early sof.
REQ-017 Port busy  output  1  high in ACTIVE and DRAIN.

Function
REQ-018 The FSM SHALL have states IDLE, ACTIVE and DRAIN.
REQ-019 IDLE SHALL move to ACTIVE on pix_valid&&sof, and SHALL ignore pix_valid without sof.
REQ-020 On entering ACTIVE, col and row SHALL be set to 0 and mode_active SHALL load mode_req; mode_active SHALL NOT change at any other time.
REQ-021 shift_en SHALL be a combinational copy of pix_valid while in ACTIVE, or while in IDLE on the accepting sof cycle; it SHALL be 0 otherwise.
REQ-022 In ACTIVE, each pix_valid without sof SHALL increment col; at col==WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 The pixel accepted at col==WIDTH-1 and row==HEIGHT-1 SHALL move the FSM to DRAIN; the counters SHALL hold.
REQ-024 win_valid SHALL be registered and high for exactly one cycle after each accepted pixel with col>=2 and row>=2; it SHALL be low after all other cycles.
REQ-025 out_valid SHALL equal win_valid delayed by exactly LATENCY clock cycles through a shift register, independent of pix_valid gaps.
REQ-026 DRAIN SHALL last exactly LATENCY cycles; on its final cycle frame_done SHALL pulse and the FSM SHALL return to IDLE.
REQ-027 A pix_valid&&sof in ACTIVE or DRAIN SHALL pulse resync, clear the win_valid/out_valid pipeline, reload mode_active, set col and row to 0, and enter or remain in ACTIVE.
REQ-028 frame_done SHALL NOT pulse for an aborted frame.
REQ-029 pix_valid in DRAIN without sof SHALL be ignored, with shift_en low.
REQ-030 Per frame, out_valid SHALL assert exactly (WIDTH-2)*(HEIGHT-2) times.
REQ-031 WIDTH>=3, HEIGHT>=3 and LATENCY>=1 SHALL be required; other values are unsupported.

Reset
REQ-032 While reset is high, the FSM SHALL go to IDLE on the next edge, with col, row and mode_active at 0.
REQ-033 While reset is high, win_valid, out_valid, frame_done, resync and busy SHALL be 0, and the delay pipeline SHALL be cleared.
REQ-034 shift_en SHALL be 0 during reset.
REQ-035 Reset SHALL override all inputs, including a coincident sof, and SHALL abort a frame mid-operation without a frame_done pulse.

Verification (WIDTH=4, HEIGHT=3, LATENCY=2)
REQ-036 Back-to-back frame, sof with mode_req=2 then 11 more pix_valid -> mode_active=2; win_valid after pixels (2,2),(3,2) only; out_valid 2 cycles later, twice; frame_done 2 cycles after the last pixel; busy low after.
REQ-037 Gapped input, pix_valid alternating 1/0 -> same col/row sequence; shift_en mirrors pix_valid; out_valid count=2.
REQ-038 Early sof at pixel 6 with mode_req=1 -> resync pulse; col=0, row=0; mode_active=1; no frame_done until the restarted frame completes.
REQ-039 sof during DRAIN -> pending out_valid is suppressed; no frame_done; the new frame starts at (0,0).
REQ-040 pix_valid without sof in IDLE -> shift_en=0, busy=0, counters unchanged.
REQ-041 reset asserted at pixel 9 with sof high -> next cycle IDLE; all outputs 0; no frame_done.

Source files
------------

// File: rtl/stream_kernel_sequencer.sv
// Sequencer for a 3x3 streaming convolution: tracks pixel position,
// gates line-buffer shifting and times window/result valid strobes.
module stream_kernel_sequencer #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid,
    input  logic                      sof,
    input  logic [1:0]                mode_req,
    output logic [1:0]                mode_active,
    output logic                      shift_en,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic                      win_valid,
    output logic                      out_valid,
    output logic                      frame_done,
    output logic                      resync,
    output logic                      busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int DW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]         state;
    logic [DW-1:0]      dcnt;
    logic [LATENCY-1:0] pipe;
    logic               win_q;
    logic               done_q;
    logic               resync_q;

    logic               start;
    logic               step;
    logic               frame_end;
    logic               win_d;
    logic [CW-1:0]      nxt_col;
    logic [RW-1:0]      nxt_row;

    assign start = pix_valid && sof;
    assign step  = (state == S_ACTIVE) && pix_valid && !sof;

    // Coordinates of the pixel accepted this cycle (if any)
    always_comb begin
        nxt_col = col;
        nxt_row = row;
        if (start) begin
            nxt_col = '0;
            nxt_row = '0;
        end else if (step) begin
            if (col == CW'(WIDTH - 1)) begin
                nxt_col = '0;
                nxt_row = row + RW'(1);
            end else begin
                nxt_col = col + CW'(1);
            end
        end
    end

    assign frame_end = step
                    && (nxt_col == CW'(WIDTH - 1))
                    && (nxt_row == RW'(HEIGHT - 1));

    assign win_d = step
                && (nxt_col >= CW'(2))
                && (nxt_row >= RW'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            dcnt        <= '0;
            col         <= '0;
            row         <= '0;
            mode_active <= '0;
            win_q       <= 1'b0;
            pipe        <= '0;
            done_q      <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            resync_q <= 1'b0;
            win_q    <= win_d;
            col      <= nxt_col;
            row      <= nxt_row;
            pipe[0]  <= win_q;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (start) begin
                // A new frame discards any results still in flight
                state       <= S_ACTIVE;
                mode_active <= mode_req;
                resync_q    <= (state != S_IDLE);
                pipe        <= '0;
                dcnt        <= '0;
            end else begin
                case (state)
                    S_ACTIVE: begin
                        if (frame_end) begin
                            state <= S_DRAIN;
                            dcnt  <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (dcnt == DW'(LATENCY - 1)) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign shift_en = !reset && pix_valid
                   && ((state == S_ACTIVE)
                    || ((state == S_IDLE) && sof));

    assign busy       = !reset
                     && ((state == S_ACTIVE) || (state == S_DRAIN));
    assign win_valid  = win_q && !reset;
    assign out_valid  = pipe[LATENCY-1] && !reset;
    assign frame_done = done_q && !reset;
    assign resync     = resync_q && !reset;

endmodule

// File: tb/tb_stream_kernel_sequencer.sv
// Directed bench for stream_kernel_sequencer at WIDTH=4, HEIGHT=3,
// LATENCY=2 with immediate assertions at every comparison.
module tb_stream_kernel_sequencer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [1:0] mode_req = 2'd0;
    logic [1:0] mode_active;
    logic       shift_en;
    logic [1:0] col;
    logic [1:0] row;
    logic       win_valid;
    logic       out_valid;
    logic       frame_done;
    logic       resync;
    logic       busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   ovc = 0;
    int   fdc = 0;
    int   ec;
    int   er;
    logic sh;

    always #5 clk = ~clk;

    stream_kernel_sequencer #(
        .WIDTH(W),
        .HEIGHT(H),
        .LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_valid(pix_valid),
        .sof(sof),
        .mode_req(mode_req),
        .mode_active(mode_active),
        .shift_en(shift_en),
        .col(col),
        .row(row),
        .win_valid(win_valid),
        .out_valid(out_valid),
        .frame_done(frame_done),
        .resync(resync),
        .busy(busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, sample shift_en before the edge, settle after it
    task automatic px(input logic pv, input logic s, input logic [1:0] m);
        pix_valid = pv;
        sof = s;
        mode_req = m;
        #1;
        sh = shift_en;
        @(posedge clk);
        #1;
        if (out_valid) ovc++;
        if (frame_done) fdc++;
    endtask

    task automatic model_step();
        if (ec == W - 1) begin
            ec = 0;
            er++;
        end else begin
            ec++;
        end
    endtask

    initial begin
        // Reset with coincident sof
        reset = 1'b1;
        px(1'b1, 1'b1, 2'd2);
        px(1'b1, 1'b1, 2'd2);
        chk("rst_shift", int'(sh), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_mode", int'(mode_active), 0);
        chk("rst_win", int'(win_valid), 0);
        chk("rst_out", int'(out_valid), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_resync", int'(resync), 0);
        reset = 1'b0;

        // pix_valid without sof in IDLE
        px(1'b1, 1'b0, 2'd0);
        chk("idle_shift", int'(sh), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_col", int'(col), 0);
        chk("idle_row", int'(row), 0);

        // Back-to-back frame
        ovc = 0;
        fdc = 0;
        px(1'b1, 1'b1, 2'd2);
        chk("bb_sof_shift", int'(sh), 1);
        chk("bb_mode", int'(mode_active), 2);
        chk("bb_col0", int'(col), 0);
        chk("bb_row0", int'(row), 0);
        chk("bb_busy", int'(busy), 1);
        ec = 0;
        er = 0;
        for (int k = 1; k <= 11; k++) begin
            px(1'b1, 1'b0, 2'd1);
            model_step();
            chk("bb_shift", int'(sh), 1);
            chk("bb_col", int'(col), ec);
            chk("bb_row", int'(row), er);
            chk("bb_win", int'(win_valid), int'(ec >= 2 && er >= 2));
        end
        chk("bb_out_early", ovc, 0);
        px(1'b1, 1'b0, 2'd0);
        chk("drain_shift", int'(sh), 0);
        chk("drain_col", int'(col), 3);
        chk("drain_row", int'(row), 2);
        chk("drain_win", int'(win_valid), 0);
        chk("drain_out1", int'(out_valid), 1);
        chk("drain_done1", int'(frame_done), 0);
        chk("drain_busy1", int'(busy), 1);
        px(1'b0, 1'b0, 2'd0);
        chk("drain_out2", int'(out_valid), 1);
        chk("drain_done2", int'(frame_done), 1);
        chk("drain_busy2", int'(busy), 0);
        px(1'b0, 1'b0, 2'd0);
        chk("post_out", int'(out_valid), 0);
        chk("post_done", int'(frame_done), 0);
        chk("bb_out_count", ovc, 2);
        chk("bb_done_count", fdc, 1);
        chk("bb_mode_hold", int'(mode_active), 2);

        // Gapped input
        ovc = 0;
        fdc = 0;
        px(1'b1, 1'b1, 2'd3);
        ec = 0;
        er = 0;
        for (int i = 0; i < 22; i++) begin
            px(logic'(i % 2), 1'b0, 2'd0);
            if (i % 2 == 1) model_step();
            chk("gap_shift", int'(sh), i % 2);
            chk("gap_col", int'(col), ec);
            chk("gap_row", int'(row), er);
        end
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, 2'd0);
        chk("gap_out_count", ovc, 2);
        chk("gap_done_count", fdc, 1);
        chk("gap_mode", int'(mode_active), 3);
        chk("gap_busy", int'(busy), 0);

        // Early sof at pixel 6
        ovc = 0;
        fdc = 0;
        px(1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 2'd0);
        px(1'b1, 1'b1, 2'd1);
        chk("early_resync", int'(resync), 1);
        chk("early_col", int'(col), 0);
        chk("early_row", int'(row), 0);
        chk("early_mode", int'(mode_active), 1);
        chk("early_busy", int'(busy), 1);
        px(1'b0, 1'b0, 2'd0);
        chk("early_resync_end", int'(resync), 0);
        chk("early_no_done", fdc, 0);
        for (int i = 0; i < 11; i++) px(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, 2'd0);
        chk("early_done_count", fdc, 1);
        chk("early_out_count", ovc, 2);
        chk("early_mode_hold", int'(mode_active), 1);

        // sof during DRAIN
        ovc = 0;
        fdc = 0;
        px(1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 11; i++) px(1'b1, 1'b0, 2'd0);
        chk("dsof_in_drain", int'(busy), 1);
        chk("dsof_out_pre", ovc, 0);
        px(1'b1, 1'b1, 2'd2);
        chk("dsof_resync", int'(resync), 1);
        chk("dsof_out", int'(out_valid), 0);
        chk("dsof_col", int'(col), 0);
        chk("dsof_row", int'(row), 0);
        chk("dsof_mode", int'(mode_active), 2);
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, 2'd0);
        chk("dsof_out_none", ovc, 0);
        chk("dsof_no_done", fdc, 0);
        chk("dsof_busy", int'(busy), 1);
        for (int i = 0; i < 11; i++) px(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, 2'd0);
        chk("dsof_done_count", fdc, 1);
        chk("dsof_out_count", ovc, 2);
        chk("dsof_busy_end", int'(busy), 0);

        // Reset at pixel 9 with sof high
        ovc = 0;
        fdc = 0;
        px(1'b1, 1'b1, 2'd1);
        for (int i = 0; i < 8; i++) px(1'b1, 1'b0, 2'd0);
        chk("mid_busy_pre", int'(busy), 1);
        reset = 1'b1;
        px(1'b1, 1'b1, 2'd3);
        chk("mid_shift", int'(sh), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_col", int'(col), 0);
        chk("mid_row", int'(row), 0);
        chk("mid_mode", int'(mode_active), 0);
        chk("mid_win", int'(win_valid), 0);
        chk("mid_out", int'(out_valid), 0);
        chk("mid_resync", int'(resync), 0);
        chk("mid_done", int'(frame_done), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, 2'd0);
        chk("mid_no_done", fdc, 0);
        chk("mid_no_out", ovc, 0);
        chk("mid_busy_after", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
